// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared state enum and Johnson code helpers
package johnson_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2,
    ERROR    = 2'd3
  } mon_state_e;

  // Helpers work on a wide container; callers pass the real code width.
  localparam int MAX_W = 32;
  typedef logic [MAX_W-1:0] code_t;

  function automatic code_t width_mask(input int w);
    code_t m;
    m = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < w) m[i] = 1'b1;
    return m;
  endfunction

  function automatic code_t johnson_next(input code_t q, input int w);
    code_t n;
    n = q << 1;
    for (int i = 0; i < MAX_W; i++)
      if (i == w - 1) n[0] = ~q[i];
    return n & width_mask(w);
  endfunction

  // A value of the form 0..01..1 has no overlap with itself plus one.
  function automatic logic johnson_legal(input code_t q, input int w);
    code_t ones;
    code_t zeros;
    ones  = q & width_mask(w);
    zeros = ~q & width_mask(w);
    return ((ones & (ones + code_t'(1))) == '0) ||
           ((zeros & (zeros + code_t'(1))) == '0);
  endfunction

  function automatic int johnson_index(input code_t q, input int w);
    int   pop;
    logic msb;
    pop = 0;
    msb = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w && q[i]) pop++;
      if (i == w - 1) msb = q[i];
    end
    return msb ? (2 * w - pop) : pop;
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// rtl/johnson_code_check.sv - classifies the sampled code against the previous one
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] q_r,
  input  logic [WIDTH-1:0] q_p,
  output logic             legal,
  output logic             step,
  output logic             hold,
  output logic [IDX_W-1:0] index
);

  code_t r_ext;
  code_t p_ext;

  assign r_ext = code_t'(q_r);
  assign p_ext = code_t'(q_p);

  always_comb begin
    legal = johnson_legal(r_ext, WIDTH);
    step  = legal && (r_ext == johnson_next(p_ext, WIDTH));
    hold  = legal && (q_r == q_p);
    index = IDX_W'(johnson_index(r_ext, WIDTH));
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// rtl/johnson_phase_monitor.sv - lock/phase/revolution monitor for a Johnson counter
module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 4,
  parameter int REV_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   q_in,
  output logic [2*WIDTH-1:0] phase,
  output logic               locked,
  output logic               err,
  output logic               preset_req,
  output logic [REV_W-1:0]   rev_count
);

  localparam int IDX_W = $clog2(2 * WIDTH);
  localparam int CNT_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;

  mon_state_e         state, state_d;
  logic [WIDTH-1:0]   q_r, q_p;
  logic [CNT_W-1:0]   lock_cnt, cnt_d;
  logic               legal, step, hold;
  logic [IDX_W-1:0]   index;
  logic [2*WIDTH-1:0] phase_d;
  logic               fault_d, rev_inc, err_q;

  johnson_code_check #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_check (
    .q_r  (q_r),
    .q_p  (q_p),
    .legal(legal),
    .step (step),
    .hold (hold),
    .index(index)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= UNLOCKED;
      lock_cnt <= '0;
      q_r      <= '0;
      q_p      <= '0;
    end else begin
      state    <= state_d;
      lock_cnt <= cnt_d;
      q_r      <= q_in;
      q_p      <= q_r;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = lock_cnt;
    case (state)
      UNLOCKED: if (legal) begin
        state_d = LOCKING;
        cnt_d   = '0;
      end
      LOCKING: begin
        if (step) begin
          if (lock_cnt == CNT_W'(LOCK_COUNT - 1)) state_d = LOCKED;
          else cnt_d = lock_cnt + CNT_W'(1);
        end else if (!hold) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end
      end
      LOCKED: if (!step && !hold) state_d = ERROR;
      ERROR: begin
        state_d = UNLOCKED;
        cnt_d   = '0;
      end
      default: begin
        state_d = UNLOCKED;
        cnt_d   = '0;
      end
    endcase
  end

  // Phase follows the state being entered so it lines up with locked.
  always_comb begin
    fault_d = (state == LOCKED) && !step && !hold;
    rev_inc = (state == LOCKED) && step && (index == '0);
    phase_d = (state_d == LOCKED) ? ((2 * WIDTH)'(1) << index) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase     <= '0;
      locked    <= 1'b0;
      err_q     <= 1'b0;
      rev_count <= '0;
    end else begin
      phase  <= phase_d;
      locked <= (state_d == LOCKED);
      err_q  <= fault_d;
      if (rev_inc) rev_count <= rev_count + REV_W'(1);
    end
  end

  assign err        = err_q;
  assign preset_req = err_q;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// tb/tb_johnson_phase_monitor.sv - scoreboard bench for johnson_phase_monitor
module tb_johnson_phase_monitor;

  localparam int LC = 4;

  logic       clk;
  logic       reset;
  logic [3:0] q_in;

  logic [7:0] phase_a, phase_b;
  logic       locked_a, locked_b, err_a, err_b, pr_a, pr_b;
  logic [7:0] rev_a;
  logic [1:0] rev_b;

  johnson_phase_monitor #(.WIDTH(4), .LOCK_COUNT(LC), .REV_W(8)) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .phase(phase_a), .locked(locked_a),
    .err(err_a), .preset_req(pr_a), .rev_count(rev_a)
  );

  johnson_phase_monitor #(.WIDTH(4), .LOCK_COUNT(LC), .REV_W(2)) dut_r2 (
    .clk(clk), .reset(reset), .q_in(q_in), .phase(phase_b), .locked(locked_b),
    .err(err_b), .preset_req(pr_b), .rev_count(rev_b)
  );

  typedef struct {
    logic [7:0] phase;
    logic       locked;
    logic       err;
    int         rev;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state: sampled code history and monitor mode.
  logic [3:0] seq[8];
  logic [3:0] m_qr, m_qp;
  int         mode;   // 0 unlocked, 1 locking, 2 locked, 3 error
  int         cnt;
  int         rev;
  bit         last_err;
  int         up;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [3:0] c);
    for (int i = 0; i < 8; i++)
      if (seq[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_qr = 4'd0; m_qp = 4'd0; mode = 0; cnt = 0; rev = 0; last_err = 0;
  endtask

  // One clock edge of the monitor as described by its rules.
  task automatic model_edge(input logic [3:0] code);
    exp_t e;
    int   ir, ip;
    bit   lg, stp, hld;
    ir  = idx_of(m_qr);
    ip  = idx_of(m_qp);
    lg  = (ir >= 0);
    stp = lg && (ip >= 0) && (ir == (ip + 1) % 8);
    hld = lg && (m_qr == m_qp);
    e.err = 1'b0;
    case (mode)
      0: if (lg) begin mode = 1; cnt = 0; end
      1: begin
        if (stp) begin
          cnt++;
          if (cnt == LC) mode = 2;
        end else if (!hld) begin
          mode = 0; cnt = 0;
        end
      end
      2: begin
        if (stp && ir == 0) rev++;
        if (!stp && !hld) begin mode = 3; e.err = 1'b1; end
      end
      default: mode = 0;
    endcase
    e.locked = (mode == 2);
    e.phase  = (mode == 2) ? 8'(1 << ir) : 8'd0;
    e.rev    = rev;
    last_err = e.err;
    m_qp = m_qr;
    m_qr = code;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] code);
    @(negedge clk);
    q_in = code;
    model_edge(code);
  endtask

  task automatic clean_steps(input int n);
    for (int i = 0; i < n; i++) begin
      up = (up + 1) % 8;
      drive(seq[up]);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    model_edge(q_in);
  endtask

  // Monitor: one expected entry per clock edge once the model is running.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("phase",       32'(phase_a),  32'(e.phase));
        chk("locked",      32'(locked_a), 32'(e.locked));
        chk("err",         32'(err_a),    32'(e.err));
        chk("preset_req",  32'(pr_a),     32'(e.err));
        chk("rev_count",   32'(rev_a),    32'(e.rev % 256));
        chk("rev_count_w2", 32'(rev_b),   32'(e.rev % 4));
        chk("locked_w2",   32'(locked_b), 32'(e.locked));
      end
    end
  end

  initial begin
    int r;
    seq[0] = 4'b0000;
    for (int i = 1; i < 8; i++) seq[i] = {seq[i-1][2:0], ~seq[i-1][3]};
    model_reset();
    reset = 1'b0;
    q_in  = 4'd0;
    up    = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_phase",  32'(phase_a), 32'd0);
    chk("reset_locked", 32'(locked_a), 32'd0);
    chk("reset_rev",    32'(rev_a), 32'd0);
    release_reset();

    // Clean revolutions from 0000.
    drive(seq[0]);
    clean_steps(24);

    // Hold 0011 while locked.
    while (up != 2) clean_steps(1);
    repeat (3) drive(seq[up]);

    // Illegal code while locked, then relock from 0000.
    drive(4'b0101);
    up = 0;
    drive(seq[0]);
    clean_steps(16);

    // Fault, then a skipped step while locking.
    drive(4'b0101);
    drive(4'b0000);
    drive(4'b0000);
    drive(4'b0001);
    drive(4'b0111);
    drive(4'b0111);
    up = 3;
    clean_steps(12);

    // Randomised traffic with an emulated upstream counter.
    for (int i = 0; i < 600; i++) begin
      if (last_err) begin
        up = 0;
        drive(seq[0]);
      end else begin
        r = $urandom_range(0, 99);
        if (r < 80) clean_steps(1);
        else if (r < 90) drive(seq[up]);
        else drive(4'($urandom_range(0, 15)));
      end
    end

    // Asynchronous reset while locked.
    clean_steps(20);
    @(posedge clk);
    #2;
    chk("locked_before_reset", 32'(locked_a), 32'(mode == 2));
    reset = 1'b0;
    #1;
    chk("async_phase",  32'(phase_a), 32'd0);
    chk("async_locked", 32'(locked_a), 32'd0);
    chk("async_err",    32'(err_a), 32'd0);
    chk("async_preset", 32'(pr_a), 32'd0);
    chk("async_rev",    32'(rev_a), 32'd0);
    chk("async_rev_w2", 32'(rev_b), 32'd0);
    model_reset();
    q_in = 4'd0;
    up = 0;
    repeat (2) @(posedge clk);
    release_reset();
    drive(seq[0]);
    clean_steps(40);

    // Long clean run so the 8-bit revolution counter wraps.
    clean_steps(2100);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/johnson_phase_monitor.md
# johnson_phase_monitor

Downstream consumer of the 4-bit Johnson counter. Samples the counter's code every clock and checks that each change is a legal Johnson step. Locks after a run of good steps, then drives a one-hot phase vector and a revolution count. On a corrupt code or skipped step it raises an error and a one-cycle `preset_req` that feeds the counter's `preset` input to resynchronise it.

## Interface
- `WIDTH`, 4: Johnson code width N; the sequence has 2N states.
- `LOCK_COUNT`, 4: number of consecutive legal steps needed to reach LOCKED (≥1).
- `REV_W`, 8: width of the revolution counter.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low; 0 clears all state immediately.
- `q_in`  in  WIDTH: code from the Johnson counter.
- `phase`  out  2*WIDTH: one-hot decoded state index.
- `locked`  out  1: monitor is in LOCKED.
- `err`  out  1: one-cycle pulse when a fault is seen in LOCKED.
- `preset_req`  out  1: one-cycle pulse, coincident with `err`; wired to the upstream `preset`.
- `rev_count`  out  REV_W: completed revolutions while locked; wraps.

## Operation
- Step rule: next(q) = {q[N-2:0], ~q[N-1]}. Sequence for N=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
- Legal code: a contiguous run of ones at the LSB end, or a contiguous run of zeros at the LSB end (2N codes).
- Index of a legal code:
  - MSB = 0: index = popcount(q).
  - MSB = 1: index = 2N − popcount(q).
- Input pipeline: `q_in` is registered into `q_r` every cycle. The previous value is kept in `q_p`, which is updated from `q_r` every cycle.
- Classification of `q_r` against `q_p`:
  - STEP: `q_r` = next(`q_p`) and `q_r` is legal.
  - HOLD: `q_r` = `q_p` and `q_r` is legal.
  - BAD: anything else (illegal code, or a jump between legal codes).
- State machine (`lock_cnt` counts good steps):
  - UNLOCKED: if `q_r` is legal → LOCKING with `lock_cnt`=0; otherwise stay.
  - LOCKING:
    - STEP: `lock_cnt`++; if `lock_cnt` = LOCK_COUNT−1 → LOCKED.
    - HOLD: stay; `lock_cnt` unchanged.
    - BAD: → UNLOCKED with `lock_cnt`=0; no `err` pulse.
  - LOCKED:
    - STEP/HOLD: stay.
    - BAD: → ERROR; `err`=1 and `preset_req`=1 for one cycle.
  - ERROR: unconditionally → UNLOCKED on the next clock.
- `phase`: one-hot of index(`q_r`) while in LOCKED; all zeros in every other state.
- `rev_count`: incremented on a STEP into index 0 while in LOCKED. Wraps modulo 2^REV_W. Not cleared by errors; cleared only by reset.

## Timing
- All outputs are registered.
- Latency: a code applied to `q_in` before edge k is reflected in `phase`, `locked` and `err` after edge k+1 (two edges).
- LOCK_COUNT legal steps from UNLOCKED, with legal codes throughout:
  - 1 edge to enter LOCKING;
  - LOCK_COUNT STEP edges to reach LOCKED.
- `err` and `preset_req` are high for exactly one cycle per fault, even if `q_in` stays bad.
- A fault during ERROR is ignored. Re-detection starts from UNLOCKED.
- Upstream preset loads 0000. The resulting jump is seen while the monitor is in UNLOCKED/LOCKING and does not generate `err`.
- Reset values: state UNLOCKED, `q_r`=`q_p`=0, `lock_cnt`=0, `phase`=0, `locked`=0, `err`=0, `preset_req`=0, `rev_count`=0.
- Reset mid-operation clears everything asynchronously. After release, operation resumes from UNLOCKED on the first edge.

## Structure
- Package `johnson_pkg` holds:
  - state enum: UNLOCKED, LOCKING, LOCKED, ERROR;
  - functions `johnson_next`, `johnson_legal` and `johnson_index`, parameterised on WIDTH.
- Sub-module `johnson_code_check` (combinational): inputs `q_r` and `q_p`; outputs `legal`, `step`, `hold` and `index`. The top level holds the registers, the FSM and the counters.

## Test plan
- Release reset, drive 0000, 0001, 0011, … stepping every clock → `locked`=1 two edges after the 4th step. `phase` then tracks 8'b0000_0001, 0000_0010, …. `rev_count`=1 after the first return to 0000 while locked.
- While locked, hold `q_in`=0011 for 3 clocks → `phase`=8'b0000_0100 stays constant, `locked` stays 1, `err` stays 0.
- While locked, inject 0101 for one clock → one pulse each of `err` and `preset_req`. `locked` goes to 0 and `phase` to 0. Drive the legal sequence from 0000 again → relock after 4 steps with no further `err`.
- In LOCKING, drive 0001 then 0111 → back to UNLOCKED, `err` never pulses, `locked` stays 0.
- Pull `reset` low mid-LOCKED between clock edges → all outputs 0 at once, without waiting for a clock edge.
- Set REV_W=2 and run 4 clean revolutions while locked → `rev_count` reads 1, 2, 3, 0.
